// File: rtl/f5_fc_layer.sv
// f5_fc_layer: single-MAC fully connected stage that follows C3S4. It buffers the pooled
// input words and runs OUT_NUM dot products. Defining F5_RELU_EN clamps negative results to zero.
module f5_fc_layer #(
  parameter int IN_NUM    = 400,
  parameter int OUT_NUM   = 120,
  parameter int FRAC_BITS = 8,
  parameter int OUT_BASE  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_wr_en,
  input  logic [31:0] in_wr_addr,
  input  logic [15:0] in_wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] w_rd_addr,
  input  logic [15:0] w_rd_data,
  output logic [7:0]  b_rd_addr,
  input  logic [15:0] b_rd_data,
  output logic        out_wr_en,
  output logic [31:0] out_wr_addr,
  output logic [15:0] out_wr_data
);
  localparam int IW    = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int OW    = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam int ACC_W = 32 + $clog2(IN_NUM);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_BIAS, S_MAC, S_FLUSH, S_WRITE, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [OW-1:0]           o_q, o_d;
  logic [IW-1:0]           i_q, i_d;
  logic [31:0]             w_addr_q, w_addr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]             out_addr_q, out_addr_d;
  logic [15:0]             out_data_q, out_data_d;

  logic signed [15:0]      buf_mem [IN_NUM];
  logic signed [15:0]      buf_rd_q;
  logic                    buf_we;

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_sum, acc_shr;
  logic [15:0]             sat_data, res_data;

  assign buf_we = (state_q == S_IDLE) && in_wr_en && (in_wr_addr < 32'(IN_NUM));

  // The buffer is plain storage: no reset, so it survives a reset of the control path.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[in_wr_addr[IW-1:0]] <= in_wr_data;
    if (state_q == S_MAC) buf_rd_q <= buf_mem[i_q];
  end

  always_comb begin
    prod     = buf_rd_q * $signed(w_rd_data);
    prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    bias_ext = {{(ACC_W-16-FRAC_BITS){b_rd_data[15]}}, b_rd_data, {FRAC_BITS{1'b0}}};
    acc_sum  = acc_q + prod_ext;
    acc_shr  = acc_sum >>> FRAC_BITS;
    if (acc_shr[ACC_W-1:15] == {(ACC_W-15){acc_shr[ACC_W-1]}}) sat_data = acc_shr[15:0];
    else sat_data = acc_shr[ACC_W-1] ? 16'h8000 : 16'h7FFF;
`ifdef F5_RELU_EN
    res_data = sat_data[15] ? 16'h0000 : sat_data;
`else
    res_data = sat_data;
`endif
  end

  always_comb begin
    state_d    = state_q;
    o_d        = o_q;
    i_d        = i_q;
    w_addr_d   = w_addr_q;
    acc_d      = acc_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD_BIAS;
          o_d      = '0;
          w_addr_d = '0;
        end
      end
      S_LOAD_BIAS: begin
        state_d = S_MAC;
        i_d     = '0;
      end
      S_MAC: begin
        // Bias arrives in the first MAC cycle; products lag their address by one cycle.
        acc_d    = (i_q == '0) ? bias_ext : acc_sum;
        w_addr_d = w_addr_q + 32'd1;
        i_d      = i_q + 1'b1;
        if (i_q == IW'(IN_NUM - 1)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        acc_d      = acc_sum;
        out_addr_d = 32'(OUT_BASE) + 32'(o_q);
        out_data_d = res_data;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (o_q == OW'(OUT_NUM - 1)) begin
          state_d = S_DONE;
        end else begin
          o_d     = o_q + 1'b1;
          state_d = S_LOAD_BIAS;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      o_q        <= '0;
      i_q        <= '0;
      w_addr_q   <= '0;
      acc_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      o_q        <= o_d;
      i_q        <= i_d;
      w_addr_q   <= w_addr_d;
      acc_q      <= acc_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy        = (state_q == S_LOAD_BIAS) || (state_q == S_MAC) ||
                       (state_q == S_FLUSH) || (state_q == S_WRITE);
  assign done        = (state_q == S_DONE);
  assign out_wr_en   = (state_q == S_WRITE);
  assign w_rd_addr   = w_addr_q;
  assign b_rd_addr   = 8'(o_q);
  assign out_wr_addr = out_addr_q;
  assign out_wr_data = out_data_q;
endmodule

// File: doc/f5_fc_layer.md
# f5_fc_layer

Fully connected stage directly downstream of the C3S4 conv/pool layer. Captures the 16×5×5 = 400 pooled words the C3S4 layer writes out, one word per cycle. On a start pulse (wired to C3S4 `work_finished`) it computes OUT_NUM fixed-point dot products against an external weight ROM and bias ROM, then writes one 16-bit result per output neuron. It uses a single-MAC, sequential architecture.

## Interface
Parameters:
- IN_NUM, 400, input vector length (input buffer depth)
- OUT_NUM, 120, number of output neurons
- FRAC_BITS, 8, fractional bits of the Q-format shared by data, weights and bias
- OUT_BASE, 0, base address added to the output neuron index

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_wr_en  in  1  input word write strobe (from C3S4 wr_out_en)
- in_wr_addr  in  32  input word index (from C3S4 wr_addr_out_1P)
- in_wr_data  in  16  signed input word
- start  in  1  single-cycle start pulse
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle completion pulse
- w_rd_addr  out  32  weight ROM address, = o*IN_NUM + i
- w_rd_data  in  16  signed weight; synchronous ROM, 1-cycle latency
- b_rd_addr  out  8  bias ROM address, = o
- b_rd_data  in  16  signed bias; 1-cycle latency
- out_wr_en  out  1  result write strobe
- out_wr_addr  out  32  OUT_BASE + o
- out_wr_data  out  16  result word

## Operation
- Input buffer:
  - IN_NUM×16 register/distributed RAM.
  - Written only in IDLE, and only when in_wr_addr < IN_NUM.
  - Out-of-range writes, and writes while busy, are dropped.
  - Contents are not cleared by reset.
- FSM states: IDLE, LOAD_BIAS, MAC, FLUSH, WRITE, DONE.
  - IDLE: start=1 → LOAD_BIAS, o=0. While busy, start is ignored.
  - LOAD_BIAS: drive b_rd_addr=o for 1 cycle → MAC, i=0.
  - MAC: each cycle issue w_rd_addr=o*IN_NUM+i and a registered buffer read of word i. Returning data is accumulated on the next cycle. After issuing i=IN_NUM-1 → FLUSH.
  - FLUSH: accumulate the last product → WRITE.
  - WRITE: out_wr_en=1 for 1 cycle. If o==OUT_NUM-1 → DONE, else o+1 → LOAD_BIAS.
  - DONE: done=1 for 1 cycle → IDLE.
- Arithmetic:
  - Each product is 16×16 signed = 32 bits.
  - The accumulator is 41-bit signed (32 + ceil(log2 IN_NUM)).
  - In the first MAC cycle the accumulator is loaded with sign-extended b_rd_data << FRAC_BITS, which discards any prior value.
  - Result: acc >>> FRAC_BITS (arithmetic shift, truncation toward −inf), saturated to [0x8000, 0x7FFF], then passed through the Configuration stage.
- Reset at any time:
  - FSM returns to IDLE; o, i and the accumulator clear.
  - All outputs go to 0, with no partial output write.

## Timing
- Reset values: busy=0, done=0, out_wr_en=0, out_wr_addr=0, out_wr_data=0, w_rd_addr=0, b_rd_addr=0.
- Let start be sampled at edge 0. Then LOAD_BIAS occupies cycle 1.
- Each neuron takes IN_NUM+3 cycles: LOAD_BIAS 1, MAC IN_NUM, FLUSH 1, WRITE 1.
- The out_wr_en for neuron o is high in cycle (o+1)*(IN_NUM+3).
- done is high in cycle OUT_NUM*(IN_NUM+3)+1. busy falls in the same cycle.
- out_wr_addr and out_wr_data are valid only while out_wr_en=1. Otherwise they hold their last value.
- A start in the same cycle as done is ignored. start is accepted again from the next IDLE cycle.
- An input write and start in the same IDLE cycle: the write is taken.

## Configuration
- F5_RELU_EN defined: after saturation, negative results (bit 15 = 1) are forced to 0x0000, matching the C3S4 ReLU convention.
- Not defined: the saturated signed result is output unchanged (linear output layer).

## Test plan
Tests 1–4 use IN_NUM=4, OUT_NUM=2, FRAC_BITS=8, OUT_BASE=0x10.

- Basic result: inputs all 0x0100, weights all 0x0080, biases 0x0000 → two writes at addr 0x10 and 0x11, data 0x0200, at cycles 7 and 14. done at cycle 15.
- Negative result: weights all 0xFF00, bias 0x0080 → −3.5.
  - With F5_RELU_EN: data 0x0000.
  - Without: data 0xFC80.
- Saturation: inputs 0x7FFF, weights 0x7FFF, bias 0x7FFF → data 0x7FFF.
  - Without F5_RELU_EN: weights 0x8000 → data 0x8000.
- Protocol:
  - A write to addr 4 is dropped; the buffer is unchanged.
  - An in_wr_en issued while busy is dropped.
  - A second start mid-run is ignored: exactly OUT_NUM writes and one done pulse.
- Reset mid-run: assert rst_n=0 during MAC of neuron 1 (full 400/120 parameters).
  - All outputs return to 0; no spurious out_wr_en.
  - A fresh start then reproduces the golden-model outputs for all 120 neurons, with done at cycle 120*403+1 = 48361.
